// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the registered 1-to-N demultiplexer.
package demux_pkg;

  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_N     = 2;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// SEL_W-to-N one-hot decoder; in_range_o flags selects that map onto a real channel.
module onehot_dec #(
  parameter int unsigned SEL_W = 1,
  parameter int unsigned N     = 2
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     onehot_o,
  output logic             in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      onehot_o[k] = (32'(sel_i) == k);
    end
    in_range_o = (32'(sel_i) < N);
  end

endmodule

// File: rtl/demux_1xn_reg.sv
// Registered 1-to-N demux with valid/ready handshake and a one-entry holding register.
// Define DEMUX_CHAN_CNT_EN to add per-channel saturating drain counters (chan_cnt).
module demux_1xn_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [SEL_W-1:0]   s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] y,
  output logic [N-1:0]       y_valid,
  input  logic [N-1:0]       y_ready,
  output logic               drop
`ifdef DEMUX_CHAN_CNT_EN
  ,
  output logic [N*CNT_W-1:0] chan_cnt
`endif
);

  if (N < 2 || N > MAX_CH || (1 << SEL_W) < N) begin : g_bad_param
    $error("demux_1xn_reg: illegal N/SEL_W combination");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   hd_q;
  logic [SEL_W-1:0]   hs_q;
  logic               drop_q;

  logic [N-1:0]       sel_oh;
  logic               sel_ok;
  logic [N-1:0]       hold_oh;
  logic               hold_ok;
  logic               accept;
  logic               drain;

  onehot_dec #(
    .SEL_W(SEL_W),
    .N    (N)
  ) u_sel_dec (
    .sel_i     (s),
    .onehot_o  (sel_oh),
    .in_range_o(sel_ok)
  );

  onehot_dec #(
    .SEL_W(SEL_W),
    .N    (N)
  ) u_hold_dec (
    .sel_i     (hs_q),
    .onehot_o  (hold_oh),
    .in_range_o(hold_ok)
  );

  // Outputs are pure functions of the holding register; unselected channels stay zero.
  always_comb begin
    y_valid = '0;
    y       = '0;
    if (state_q == ST_FULL && hold_ok) begin
      y_valid = hold_oh;
      for (int unsigned k = 0; k < N; k++) begin
        if (hold_oh[k]) begin
          y[k*WIDTH +: WIDTH] = hd_q;
        end
      end
    end
  end

  // Masking with y_valid makes y_ready of unselected channels irrelevant.
  assign drain    = |(y_valid & y_ready);
  assign in_ready = (state_q == ST_EMPTY) || drain;
  assign accept   = in_valid && in_ready;
  assign drop     = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      hd_q    <= '0;
      hs_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= accept && !sel_ok;
      if (accept && sel_ok) begin
        // Covers simultaneous drain: the new word overwrites in the same edge.
        state_q <= ST_FULL;
        hd_q    <= a;
        hs_q    <= s;
      end else if (drain) begin
        state_q <= ST_EMPTY;
      end
    end
  end

`ifdef DEMUX_CHAN_CNT_EN
  logic [N*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (y_valid[k] && y_ready[k] && (cnt_q[k*CNT_W +: CNT_W] != '1)) begin
          cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign chan_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Scoreboard bench for demux_1xn_reg: a 4-channel and a 3-channel (out-of-range select) instance.
module tb_demux_1xn_reg;

  typedef struct {
    int         chan;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         c;
    logic [3:0] v;
  } log_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-channel instance
  logic [7:0]  a4 = '0;
  logic [1:0]  s4 = '0;
  logic        iv4 = 1'b0;
  logic        ir4;
  logic [31:0] y4;
  logic [3:0]  yv4;
  logic [3:0]  yr4 = '0;
  logic        drop4;

  // 3-channel instance
  logic [7:0]  a3 = '0;
  logic [1:0]  s3 = '0;
  logic        iv3 = 1'b0;
  logic        ir3;
  logic [23:0] y3;
  logic [2:0]  yv3;
  logic [2:0]  yr3 = '0;
  logic        drop3;

`ifdef DEMUX_CHAN_CNT_EN
  logic [63:0] cnt4;
  logic [47:0] cnt3;
`endif

  demux_1xn_reg #(
    .WIDTH(8),
    .N    (4),
    .SEL_W(2)
  ) dut4 (
    .clk     (clk),
    .rst     (rst),
    .a       (a4),
    .s       (s4),
    .in_valid(iv4),
    .in_ready(ir4),
    .y       (y4),
    .y_valid (yv4),
    .y_ready (yr4),
    .drop    (drop4)
`ifdef DEMUX_CHAN_CNT_EN
    ,
    .chan_cnt(cnt4)
`endif
  );

  demux_1xn_reg #(
    .WIDTH(8),
    .N    (3),
    .SEL_W(2)
  ) dut3 (
    .clk     (clk),
    .rst     (rst),
    .a       (a3),
    .s       (s3),
    .in_valid(iv3),
    .in_ready(ir3),
    .y       (y3),
    .y_valid (yv3),
    .y_ready (yr3),
    .drop    (drop3)
`ifdef DEMUX_CHAN_CNT_EN
    ,
    .chan_cnt(cnt3)
`endif
  );

  exp_t q4[$];
  exp_t q3[$];
  log_t dlog[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: a drain happens at the next rising edge whenever valid&ready at the falling edge.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && |(yv4 & yr4)) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon4_unexpected: drain y_valid=%0h, expected no drain", yv4);
      end else begin
        e = q4.pop_front();
        check("mon4_valid", 64'(yv4), 64'(4'b0001 << e.chan));
        check("mon4_data", 64'(y4), 64'(32'(e.data) << (8 * e.chan)));
        dlog.push_back('{cyc, yv4});
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && |(yv3 & yr3)) begin
      if (q3.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon3_unexpected: drain y_valid=%0h, expected no drain", yv3);
      end else begin
        e = q3.pop_front();
        check("mon3_valid", 64'(yv3), 64'(3'b001 << e.chan));
        check("mon3_data", 64'(y3), 64'(24'(e.data) << (8 * e.chan)));
      end
    end
  end

  // Present a word, wait (bounded) for in_ready, log the expected drain, return just after the edge.
  task automatic send4(input logic [7:0] d, input logic [1:0] sel);
    int k = 0;
    a4 = d;
    s4 = sel;
    iv4 = 1'b1;
    @(negedge clk);
    while (!ir4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ir4) begin
      n_vec++;
      n_err++;
      $display("FAIL send4_timeout: in_ready=0, expected 1");
    end else begin
      q4.push_back('{int'(sel), d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send3(input logic [7:0] d, input logic [1:0] sel);
    int k = 0;
    a3 = d;
    s3 = sel;
    iv3 = 1'b1;
    @(negedge clk);
    while (!ir3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ir3) begin
      n_vec++;
      n_err++;
      $display("FAIL send3_timeout: in_ready=0, expected 1");
    end else if (sel < 3) begin
      q3.push_back('{int'(sel), d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_y", 64'(y4), 64'h0);
    check("rst_y_valid", 64'(yv4), 64'h0);
    check("rst_in_ready", 64'(ir4), 64'h1);
    check("rst_drop", 64'(drop4), 64'h0);
    check("rst3_y_valid", 64'(yv3), 64'h0);
    check("rst3_in_ready", 64'(ir3), 64'h1);
    @(posedge clk);
    #1;

    // Basic route, one cycle latency
    yr4 = 4'b1111;
    send4(8'hA5, 2'd2);
    iv4 = 1'b0;
    @(negedge clk);
    check("basic_y_valid", 64'(yv4), 64'h4);
    check("basic_y", 64'(y4), 64'h00A5_0000);
    @(posedge clk);
    #1;

    // Backpressure on channel 1; other ready bits high must be ignored
    yr4 = 4'b1101;
    send4(8'h3C, 2'd1);
    iv4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(ir4), 64'h0);
      check("bp_y", 64'(y4), 64'h0000_3C00);
      check("bp_y_valid", 64'(yv4), 64'h2);
    end
    @(posedge clk);
    #1;
    yr4 = 4'b1111;
    @(negedge clk);
    check("bp_release_in_ready", 64'(ir4), 64'h1);
    @(negedge clk);
    check("bp_after_y_valid", 64'(yv4), 64'h0);
    check("bp_after_in_ready", 64'(ir4), 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back stream with simultaneous drain/accept
    dlog.delete();
    send4(8'd1, 2'd0);
    send4(8'd2, 2'd1);
    send4(8'd3, 2'd2);
    send4(8'd4, 2'd3);
    iv4 = 1'b0;
    repeat (3) @(negedge clk);
    check("stream_drains", 64'(dlog.size()), 64'd4);
    for (int i = 1; i < 4 && i < dlog.size(); i++) begin
      check("stream_walk", 64'(dlog[i].v), 64'(4'b0001 << i));
      check("stream_no_bubble", 64'(dlog[i].c), 64'(dlog[0].c + i));
    end
`ifdef DEMUX_CHAN_CNT_EN
    check("cnt_after_stream", cnt4, 64'h0001_0002_0002_0001);
`endif
    @(posedge clk);
    #1;

    // Out-of-range select on the 3-channel instance
    yr3 = 3'b111;
    send3(8'hFF, 2'd3);
    iv3 = 1'b0;
    @(negedge clk);
    check("oor_drop", 64'(drop3), 64'h1);
    check("oor_y_valid", 64'(yv3), 64'h0);
    @(negedge clk);
    check("oor_drop_pulse", 64'(drop3), 64'h0);
    @(posedge clk);
    #1;
    send3(8'h5A, 2'd1);
    iv3 = 1'b0;
    @(negedge clk);
    check("oor_next_y_valid", 64'(yv3), 64'h2);
    check("oor_next_y", 64'(y3), 64'h00_5A00);
    @(posedge clk);
    #1;
    // Discard while the held word drains: block must go empty
    send3(8'h11, 2'd0);
    send3(8'hEE, 2'd3);
    iv3 = 1'b0;
    @(negedge clk);
    check("oor_drain_drop", 64'(drop3), 64'h1);
    check("oor_drain_y_valid", 64'(yv3), 64'h0);
    @(posedge clk);
    #1;

    // Reset mid-operation
    yr4 = 4'b0000;
    send4(8'h77, 2'd3);
    iv4 = 1'b0;
    @(negedge clk);
    check("mid_full_y_valid", 64'(yv4), 64'h8);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q4.delete();
    @(negedge clk);
    check("mid_rst_y_valid", 64'(yv4), 64'h0);
    check("mid_rst_in_ready", 64'(ir4), 64'h1);
    check("mid_rst_y", 64'(y4), 64'h0);
`ifdef DEMUX_CHAN_CNT_EN
    check("mid_rst_cnt4", cnt4, 64'h0);
    check("mid_rst_cnt3", 64'(cnt3), 64'h0);
`endif
    yr4 = 4'b1111;
    repeat (3) @(negedge clk);

    check("sb4_empty", 64'(q4.size()), 64'd0);
    check("sb3_empty", 64'(q3.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
